jtkcpu_useq: RTL and testbench

- Parametrised microcode sequencer for the JTKCPU family.
- Generates the microcode ROM address from the opcode category, ucode control strobes and pending interrupts.
- Over the current fixed sequencer it adds:
  - N prioritised interrupt channels, each configurable as edge or level.
  - A microcode call/return stack.
  - A hardware repeat counter for string/loop ops.
- Sits between the opcode decoder (which supplies the category) and the ucode ROM.

---
 rtl/jtkcpu_useq_pkg.sv | 27 ++
 rtl/jtkcpu_ustack.sv | 54 +++++
 rtl/jtkcpu_useq.sv | 191 +++++++++++++++++++
 tb/tb_jtkcpu_useq.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtkcpu_useq_pkg.sv
// Shared definitions for the JTKCPU microcode sequencer and the opcode decoder.
// Holds the default category constants (reset entry, interrupt entry base),
// the offset-width helper and the action encoding used inside the sequencer.
package jtkcpu_useq_pkg;

  localparam int              DEF_UAW      = 12;
  localparam int              DEF_CAW      = 7;
  localparam logic [6:0]      DEF_RST_CAT  = 7'h00;
  localparam logic [6:0]      DEF_INT_BASE = 7'h7C;

  // The microcode address is {category, offset}; offset takes the remaining bits.
  function automatic int useq_ow(input int uaw, input int caw);
    return uaw - caw;
  endfunction

  // One action is applied per active cycle, highest priority first.
  typedef enum logic [2:0] {
    ACT_IDLE,
    ACT_NI,
    ACT_RET,
    ACT_CALL,
    ACT_JMP,
    ACT_JNZ,
    ACT_INC
  } useq_act_e;

endpackage

// File: rtl/jtkcpu_ustack.sv
// Microcode return-address stack: LIFO of UAW-bit entries, SDEPTH deep.
// Ports:
//   clk, rst (async, active-high), cen  - clock, reset, clock enable
//   push, pop                           - requests (at most one per cycle)
//   din                                 - value to push
//   dout                                - combinational top of stack
//   lvl                                 - number of stored entries
//   ovf, unf                            - combinational: this request would
//                                         overflow/underflow; it is then ignored
module jtkcpu_ustack #(
  parameter int UAW    = 12,
  parameter int SDEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cen,
  input  logic                        push,
  input  logic                        pop,
  input  logic [UAW-1:0]              din,
  output logic [UAW-1:0]              dout,
  output logic [$clog2(SDEPTH):0]     lvl,
  output logic                        ovf,
  output logic                        unf
);

  localparam int             SW   = $clog2(SDEPTH);
  localparam logic [SW:0]    FULL = (SW+1)'(SDEPTH);

  logic [UAW-1:0] mem_q [SDEPTH];
  logic [SW:0]    lvl_q;
  logic [SW-1:0]  top_idx;

  // When full the low bits of lvl are zero, so the decrement wraps to SDEPTH-1.
  assign top_idx = lvl_q[SW-1:0] - SW'(1);
  assign dout    = mem_q[top_idx];
  assign lvl     = lvl_q;
  assign ovf     = push && (lvl_q == FULL);
  assign unf     = pop  && (lvl_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q <= '0;
      for (int i = 0; i < SDEPTH; i++) mem_q[i] <= '0;
    end else if (cen) begin
      if (push && !ovf) begin
        mem_q[lvl_q[SW-1:0]] <= din;
        lvl_q                <= lvl_q + (SW+1)'(1);
      end else if (pop && !unf) begin
        lvl_q <= lvl_q - (SW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/jtkcpu_useq.sv
// JTKCPU microcode sequencer. Produces the ucode ROM address from the opcode
// category, the ucode control strobes, a call/return stack, a repeat counter
// and NINT prioritised interrupt channels (edge or level per channel).
// Handshake: there is no valid/ready pair; a cycle is "active" when
// cen && !fault && !stall, and only active cycles consume the strobes.
// Ports:
//   clk, rst (async, active-high), cen, stall
//   opcat, ni, jmp, call, ret, tgt   - sequencing controls
//   rep_ld, rep_val, rep_jnz         - repeat counter controls
//   irq_n, irq_mask                  - interrupt lines (active low) and masks
//   uaddr, intvec                    - ROM address, one-hot serviced interrupt
//   intsrv                           - combinational: an unmasked irq is pending
//   rep_zero, stk_lvl, fault         - counter==0, stack depth, sticky fault
module jtkcpu_useq
  import jtkcpu_useq_pkg::*;
#(
  parameter int              UAW      = DEF_UAW,
  parameter int              CAW      = DEF_CAW,
  parameter int              NINT     = 3,
  parameter logic [NINT-1:0] EDGE     = 3'b001,
  parameter logic [CAW-1:0]  INT_BASE = DEF_INT_BASE,
  parameter logic [CAW-1:0]  RST_CAT  = DEF_RST_CAT,
  parameter int              SDEPTH   = 4,
  parameter int              CW       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cen,
  input  logic                     stall,
  input  logic [CAW-1:0]           opcat,
  input  logic                     ni,
  input  logic                     jmp,
  input  logic                     call,
  input  logic                     ret,
  input  logic [CAW-1:0]           tgt,
  input  logic                     rep_ld,
  input  logic [CW-1:0]            rep_val,
  input  logic                     rep_jnz,
  input  logic [NINT-1:0]          irq_n,
  input  logic [NINT-1:0]          irq_mask,
  output logic [UAW-1:0]           uaddr,
  output logic [NINT-1:0]          intvec,
  output logic                     intsrv,
  output logic                     rep_zero,
  output logic [$clog2(SDEPTH):0]  stk_lvl,
  output logic                     fault
);

  localparam int OW = useq_ow(UAW, CAW);

  logic [UAW-1:0]  uaddr_q,  uaddr_d;
  logic [NINT-1:0] intvec_q, intvec_d;
  logic [NINT-1:0] irq_q,    irq_d;
  logic [NINT-1:0] latch_q,  latch_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic [UAW-1:0]  loop_q,   loop_d;
  logic            fault_q,  fault_d;

  logic [NINT-1:0] pend, sel, latch_clr;
  logic [CAW-1:0]  sel_idx;
  logic            found, active, stk_err, ovf, unf;
  logic [UAW-1:0]  uaddr_inc, stk_top;
  useq_act_e       act;

  assign active    = cen && !fault_q && !stall;
  assign uaddr_inc = uaddr_q + UAW'(1);
  assign stk_err   = ovf || unf;

  // Pending vector and lowest-index (highest priority) selection.
  always_comb begin
    pend    = '0;
    sel     = '0;
    sel_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NINT; k++) begin
      pend[k] = (EDGE[k] ? latch_q[k] : !irq_n[k]) && !irq_mask[k];
      if (pend[k] && !found) begin
        sel[k]  = 1'b1;
        sel_idx = CAW'(k);
        found   = 1'b1;
      end
    end
  end

  // rep_ld together with rep_jnz suppresses the loop-back: plain increment.
  always_comb begin
    act = ACT_IDLE;
    if (active) begin
      if (ni)                      act = ACT_NI;
      else if (ret)                act = ACT_RET;
      else if (call)               act = ACT_CALL;
      else if (jmp)                act = ACT_JMP;
      else if (rep_jnz && !rep_ld) act = ACT_JNZ;
      else                         act = ACT_INC;
    end
  end

  jtkcpu_ustack #(
    .UAW    (UAW),
    .SDEPTH (SDEPTH)
  ) u_stack (
    .clk  (clk),
    .rst  (rst),
    .cen  (cen),
    .push (act == ACT_CALL),
    .pop  (act == ACT_RET),
    .din  (uaddr_inc),
    .dout (stk_top),
    .lvl  (stk_lvl),
    .ovf  (ovf),
    .unf  (unf)
  );

  always_comb begin
    uaddr_d   = uaddr_q;
    intvec_d  = intvec_q;
    cnt_d     = cnt_q;
    loop_d    = loop_q;
    fault_d   = fault_q || stk_err;
    latch_clr = '0;
    irq_d     = irq_q;
    latch_d   = latch_q;

    // A stack error leaves every sequencing register untouched.
    if (!stk_err) begin
      case (act)
        ACT_NI: begin
          if (found) begin
            uaddr_d   = {INT_BASE + sel_idx, {OW{1'b0}}};
            intvec_d  = sel;
            latch_clr = sel & EDGE;
          end else begin
            uaddr_d  = {opcat, {OW{1'b0}}};
            intvec_d = '0;
          end
        end
        ACT_RET:  uaddr_d = stk_top;
        ACT_CALL: uaddr_d = {tgt, {OW{1'b0}}};
        ACT_JMP:  uaddr_d = {tgt, {OW{1'b0}}};
        ACT_JNZ: begin
          if (cnt_q != '0) begin
            cnt_d   = cnt_q - CW'(1);
            uaddr_d = loop_q;
          end else begin
            uaddr_d = uaddr_inc;
          end
        end
        ACT_INC:  uaddr_d = uaddr_inc;
        default:  uaddr_d = uaddr_q;
      endcase
      if (active && rep_ld) begin
        cnt_d  = rep_val;
        loop_d = uaddr_inc;
      end
    end

    // Interrupt sampling runs on every cen, even when stalled or frozen.
    // A new falling edge wins over a dispatch clear in the same cycle.
    if (cen) begin
      irq_d   = irq_n;
      latch_d = (latch_q & ~latch_clr) | (irq_q & ~irq_n & EDGE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uaddr_q  <= {RST_CAT, {OW{1'b0}}};
      intvec_q <= '0;
      irq_q    <= '1;
      latch_q  <= '0;
      cnt_q    <= '0;
      loop_q   <= '0;
      fault_q  <= 1'b0;
    end else begin
      uaddr_q  <= uaddr_d;
      intvec_q <= intvec_d;
      irq_q    <= irq_d;
      latch_q  <= latch_d;
      cnt_q    <= cnt_d;
      loop_q   <= loop_d;
      fault_q  <= fault_d;
    end
  end

  assign uaddr    = uaddr_q;
  assign intvec   = intvec_q;
  assign intsrv   = found;
  assign rep_zero = (cnt_q == '0);
  assign fault    = fault_q;

endmodule

// File: tb/tb_jtkcpu_useq.sv
module tb_jtkcpu_useq;

  localparam int         UAW      = 12;
  localparam int         CAW      = 7;
  localparam int         NINT     = 3;
  localparam int         SDEPTH   = 4;
  localparam int         CW       = 16;
  localparam int         OW       = UAW - CAW;
  localparam int         INT_BASE = 'h7C;
  localparam int         RST_CAT  = 'h00;
  localparam logic [2:0] EDGE     = 3'b001;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cen, stall, ni, jmp, call, ret, rep_ld, rep_jnz;
  logic [CAW-1:0]  opcat, tgt;
  logic [CW-1:0]   rep_val;
  logic [NINT-1:0] irq_n, irq_mask;
  logic [UAW-1:0]  uaddr;
  logic [NINT-1:0] intvec;
  logic            intsrv, rep_zero, fault;
  logic [2:0]      stk_lvl;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  jtkcpu_useq dut (
    .clk(clk), .rst(rst), .cen(cen), .stall(stall),
    .opcat(opcat), .ni(ni), .jmp(jmp), .call(call), .ret(ret), .tgt(tgt),
    .rep_ld(rep_ld), .rep_val(rep_val), .rep_jnz(rep_jnz),
    .irq_n(irq_n), .irq_mask(irq_mask),
    .uaddr(uaddr), .intvec(intvec), .intsrv(intsrv), .rep_zero(rep_zero),
    .stk_lvl(stk_lvl), .fault(fault)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int              m_uaddr, m_intvec, m_cnt, m_loop;
  bit              m_fault;
  bit              m_latch [NINT];
  bit              m_prev  [NINT];
  logic [UAW-1:0]  m_stack [$];

  function automatic int pend_idx();
    for (int k = 0; k < NINT; k++) begin
      bit p;
      p = EDGE[k] ? m_latch[k] : !irq_n[k];
      if (p && !irq_mask[k]) return k;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int  old, k;
    bit  err;
    if (rst) begin
      m_uaddr  = RST_CAT << OW;
      m_intvec = 0;
      m_cnt    = 0;
      m_loop   = 0;
      m_fault  = 1'b0;
      m_stack.delete();
      for (int j = 0; j < NINT; j++) begin
        m_latch[j] = 1'b0;
        m_prev[j]  = 1'b1;
      end
    end else if (cen) begin
      old = m_uaddr;
      err = 1'b0;
      k   = pend_idx();
      if (!m_fault && !stall) begin
        if (ni) begin
          if (k >= 0) begin
            m_uaddr    = (INT_BASE + k) << OW;
            m_intvec   = 1 << k;
            m_latch[k] = 1'b0;
          end else begin
            m_uaddr  = int'(opcat) << OW;
            m_intvec = 0;
          end
        end else if (ret) begin
          if (m_stack.size() == 0) err = 1'b1;
          else m_uaddr = int'(m_stack.pop_back());
        end else if (call) begin
          if (m_stack.size() == SDEPTH) err = 1'b1;
          else begin
            m_stack.push_back(UAW'((old + 1) % 4096));
            m_uaddr = int'(tgt) << OW;
          end
        end else if (jmp) begin
          m_uaddr = int'(tgt) << OW;
        end else if (rep_jnz && !rep_ld && m_cnt != 0) begin
          m_cnt   = m_cnt - 1;
          m_uaddr = m_loop;
        end else begin
          m_uaddr = (old + 1) % 4096;
        end
        if (err) m_fault = 1'b1;
        else if (rep_ld) begin
          m_cnt  = int'(rep_val);
          m_loop = (old + 1) % 4096;
        end
      end
      for (int j = 0; j < NINT; j++) begin
        if (EDGE[j] && m_prev[j] && !irq_n[j]) m_latch[j] = 1'b1;
        m_prev[j] = irq_n[j];
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("uaddr",    int'(uaddr),    m_uaddr);
      check("intvec",   int'(intvec),   m_intvec);
      check("intsrv",   int'(intsrv),   int'(pend_idx() >= 0));
      check("rep_zero", int'(rep_zero), int'(m_cnt == 0));
      check("stk_lvl",  int'(stk_lvl),  m_stack.size());
      check("fault",    int'(fault),    int'(m_fault));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cen = 1'b1; stall = 1'b0; ni = 1'b0; jmp = 1'b0; call = 1'b0; ret = 1'b0;
    rep_ld = 1'b0; rep_jnz = 1'b0; rep_val = '0; opcat = '0; tgt = '0;
  endtask

  task automatic do_reset();
    idle();
    irq_n = '1; irq_mask = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    irq_n = '1; irq_mask = '0;
    #3;
    do_reset();
    chk_en = 1'b1;

    // 1: reset, increment, ni with no interrupt
    check("t1_reset_uaddr", int'(uaddr), 'h000);
    check("t1_reset_intvec", int'(intvec), 0);
    cyc();
    check("t1_inc", int'(uaddr), 'h001);
    ni = 1'b1; opcat = 7'h05;
    cyc();
    check("t1_ni", int'(uaddr), 'h0A0);
    check("t1_intvec", int'(intvec), 0);
    idle();

    // 2: ch0 falling edge and ch1 level low together, then two ni
    irq_n = 3'b100;
    cyc();
    check("t2_intsrv", int'(intsrv), 1);
    ni = 1'b1;
    cyc();
    check("t2_ch0_uaddr", int'(uaddr), 'hF80);
    check("t2_ch0_vec", int'(intvec), 'b001);
    cyc();
    check("t2_ch1_uaddr", int'(uaddr), 'hFA0);
    check("t2_ch1_vec", int'(intvec), 'b010);
    irq_n = 3'b111; opcat = 7'h06;
    cyc();
    check("t2_back", int'(uaddr), 'h0C0);
    idle();

    // 3: masked edge is remembered until unmasked
    irq_mask = 3'b001; irq_n = 3'b110;
    cyc();
    irq_n = 3'b111;
    repeat (10) cyc();
    check("t3_masked", int'(intsrv), 0);
    irq_mask = 3'b000;
    #1;
    check("t3_unmasked", int'(intsrv), 1);
    ni = 1'b1; opcat = 7'h05;
    cyc();
    check("t3_entry", int'(uaddr), 'hF80);
    check("t3_vec", int'(intvec), 'b001);
    check("t3_cleared", int'(intsrv), 0);
    cyc();
    check("t3_no_reentry", int'(uaddr), 'h0A0);
    idle();

    // 4: repeat loop
    jmp = 1'b1; tgt = 7'h10;
    cyc();
    check("t4_jmp", int'(uaddr), 'h200);
    idle(); rep_ld = 1'b1; rep_val = 16'd3;
    cyc();
    check("t4_ld", int'(uaddr), 'h201);
    check("t4_cnt_nz", int'(rep_zero), 0);
    idle();
    cyc();
    for (int p = 0; p < 4; p++) begin
      check("t4_at_jnz", int'(uaddr), 'h202);
      if (p == 3) check("t4_zero", int'(rep_zero), 1);
      rep_jnz = 1'b1;
      cyc();
      rep_jnz = 1'b0;
      if (p < 3) begin
        check("t4_loop", int'(uaddr), 'h201);
        cyc();
      end else begin
        check("t4_exit", int'(uaddr), 'h203);
      end
    end
    idle();

    // 5: ret on empty stack, call/ret round trip, overflow freeze
    do_reset();
    ret = 1'b1;
    cyc();
    check("t5_unf_fault", int'(fault), 1);
    check("t5_unf_uaddr", int'(uaddr), 'h000);
    do_reset();
    call = 1'b1; tgt = 7'h03;
    cyc();
    check("t5_call", int'(uaddr), 'h060);
    idle(); ret = 1'b1;
    cyc();
    check("t5_ret", int'(uaddr), 'h001);
    check("t5_ret_lvl", int'(stk_lvl), 0);
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      call = 1'b1; tgt = 7'(i);
      cyc();
      if (i <= 4) begin
        check("t5_lvl", int'(stk_lvl), i);
        check("t5_tgt", int'(uaddr), i << OW);
      end else begin
        check("t5_ovf_fault", int'(fault), 1);
        check("t5_ovf_uaddr", int'(uaddr), 'h080);
        check("t5_ovf_lvl", int'(stk_lvl), 4);
      end
    end
    idle(); jmp = 1'b1; tgt = 7'h11; irq_n = 3'b110;
    cyc();
    check("t5_frozen", int'(uaddr), 'h080);
    check("t5_edge_frozen", int'(intsrv), 1);
    idle();

    // 6: stall holds uaddr with ni asserted
    do_reset();
    stall = 1'b1; ni = 1'b1; opcat = 7'h22;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t6_stall", int'(uaddr), 'h000);
    end
    stall = 1'b0;
    cyc();
    check("t6_after", int'(uaddr), 'h440);
    idle();

    // random phase
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cen     = ($urandom_range(0, 9) != 0);
      stall   = ($urandom_range(0, 6) == 0);
      ni      = ($urandom_range(0, 6) == 0);
      ret     = ($urandom_range(0, 7) == 0);
      call    = ($urandom_range(0, 7) == 0);
      jmp     = ($urandom_range(0, 14) == 0);
      rep_jnz = ($urandom_range(0, 3) == 0);
      rep_ld  = ($urandom_range(0, 12) == 0);
      rep_val = CW'($urandom_range(0, 4));
      opcat   = CAW'($urandom_range(0, 127));
      tgt     = CAW'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0)  irq_n    = NINT'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) irq_mask = NINT'($urandom_range(0, 7));
      rst = ((m_fault && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0;
    idle();
    cyc();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
